// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: state encoding, default magic
// bytes and frame header constants.
package boot_loader_pkg;

  // Default header bytes and address width for the loader.
  localparam logic [7:0] DEF_MAGIC_HOLD = 8'hA5;
  localparam logic [7:0] DEF_MAGIC_RUN  = 8'hA6;
  localparam int         DEF_ADDR_W     = 16;

  // Number of bytes in a frame header: magic, addr_hi, addr_lo, len_hi, len_lo.
  localparam int HDR_LEN = 5;

  // One-hot parser state. ST_SPARE is never entered on purpose; it is
  // decoded back to ST_MAGIC so a corrupted state register recovers.
  typedef enum logic [8:0] {
    ST_MAGIC   = 9'b0_0000_0001,
    ST_ADDR_HI = 9'b0_0000_0010,
    ST_ADDR_LO = 9'b0_0000_0100,
    ST_LEN_HI  = 9'b0_0000_1000,
    ST_LEN_LO  = 9'b0_0001_0000,
    ST_DATA    = 9'b0_0010_0000,
    ST_CSUM    = 9'b0_0100_0000,
    ST_RUN     = 9'b0_1000_0000,
    ST_SPARE   = 9'b1_0000_0000
  } state_e;

  // True when a byte opens a new frame.
  function automatic logic is_magic(input logic [7:0] b,
                                    input logic [7:0] hold,
                                    input logic [7:0] run);
    return (b == hold) || (b == run);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Program loader: parses load frames from a byte stream while the cpu is
// held in reset, writes payload bytes to memory, and releases the cpu after
// a run frame with a good checksum.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC_HOLD = DEF_MAGIC_HOLD,
  parameter logic [7:0] MAGIC_RUN  = DEF_MAGIC_RUN,
  parameter int         ADDR_W     = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

  state_e              state_q, state_d;
  logic                run_q, run_d;
  logic [7:0]          csum_q, csum_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         ptr_q, ptr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                err_q, err_d;
  logic                accept;

  assign rx_ready  = (state_q != ST_RUN);
  assign accept    = rx_valid && rx_ready;
  assign busy      = (state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_LEN_HI,
                                      ST_LEN_LO, ST_DATA, ST_CSUM});
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign cpu_reset = cpu_reset_q;
  assign err       = err_q;

  // Frame parser: next state and all registered outputs, one byte per cycle.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    csum_d      = csum_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_reset_d = cpu_reset_q;
    err_d       = err_q;

    case (state_q)
      ST_MAGIC: begin
        if (accept && is_magic(rx_data, MAGIC_HOLD, MAGIC_RUN)) begin
          state_d = ST_ADDR_HI;
          run_d   = (rx_data == MAGIC_RUN);
          err_d   = 1'b0;
          csum_d  = 8'h00;
        end
      end
      ST_ADDR_HI: begin
        if (accept) begin
          ptr_d   = {rx_data, ptr_q[7:0]};
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (accept) begin
          ptr_d   = {ptr_q[15:8], rx_data};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          count_d = {rx_data, count_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          count_d = {count_q[15:8], rx_data};
          state_d = ({count_q[15:8], rx_data} != 16'h0000) ? ST_DATA : ST_CSUM;
        end
      end
      ST_DATA: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q[ADDR_W-1:0];
          mem_data_d = rx_data;
          ptr_d      = ptr_q + 16'd1;
          csum_d     = csum_q ^ rx_data;
          count_d    = count_q - 16'd1;
          if (count_q == 16'd1) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            if (run_q) begin
              state_d     = ST_RUN;
              cpu_reset_d = 1'b0;
            end else begin
              state_d = ST_MAGIC;
            end
          end else begin
            state_d = ST_MAGIC;
            err_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_MAGIC;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (R) begin
      state_q     <= ST_MAGIC;
      run_q       <= 1'b0;
      csum_q      <= 8'h00;
      count_q     <= 16'h0000;
      ptr_q       <= 16'h0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 8'h00;
      cpu_reset_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      csum_q      <= csum_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_reset_q <= cpu_reset_d;
      err_q       <= err_d;
    end
  end

endmodule
